// File: rtl/branch_predict_btb_pkg.sv
// Shared BTB definitions: index/tag geometry helpers, the weakly-taken counter
// value and the entry record seen by the lookup and update paths.
package branch_predict_btb_pkg;

    // Tags are kept zero-extended to the widest case so one record type fits every ENTRIES.
    typedef struct packed {
        logic        valid;
        logic [29:0] tag;
        logic [31:0] target;
        logic [2:0]  ctr;
    } btb_entry_t;

    function automatic int btb_idx_w(input int entries);
        return $clog2(entries);
    endfunction

    function automatic int btb_tag_w(input int entries);
        return 30 - $clog2(entries);
    endfunction

    function automatic logic [2:0] weak_taken(input int ctr_w);
        return 3'(1 << (ctr_w - 1));
    endfunction

    function automatic logic [29:0] btb_tag(input logic [31:0] pc, input int idx_w);
        return 30'(pc >> (idx_w + 2));
    endfunction

endpackage

// File: rtl/branch_predict_btb_sat_counter.sv
// Saturating up/down direction counter with a parallel load; load wins over inc/dec.
module branch_predict_btb_sat_counter #(
    parameter int CTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_inc,
    input  logic             i_dec,
    input  logic             i_load,
    input  logic [CTR_W-1:0] i_load_val,
    output logic [CTR_W-1:0] o_count
);

    localparam logic [CTR_W-1:0] CTR_MAX = '1;

    logic [CTR_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_inc && (r_count != CTR_MAX)) begin
            r_count <= r_count + CTR_W'(1);
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - CTR_W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/branch_predict_btb.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters,
// resolve-time mispredict/redirect generation and saturating hit/mispredict statistics.
module branch_predict_btb
    import branch_predict_btb_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int STAT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [31:0]       pred_target,
    input  logic              upd_valid,
    input  logic [31:0]       upd_pc,
    input  logic              upd_taken,
    input  logic [31:0]       upd_target,
    input  logic              upd_pred_taken,
    input  logic [31:0]       upd_pred_target,
    input  logic              inval_all,
    output logic              mispredict,
    output logic [31:0]       redirect_pc,
    output logic [STAT_W-1:0] hit_count,
    output logic [STAT_W-1:0] mispred_count
);

    localparam int               IDX_W    = btb_idx_w(ENTRIES);
    localparam logic [2:0]       WEAK3    = weak_taken(CTR_W);
    localparam logic [CTR_W-1:0] CTR_WEAK = WEAK3[CTR_W-1:0];

    logic              r_valid  [ENTRIES];
    logic [29:0]       r_tag    [ENTRIES];
    logic [31:0]       r_target [ENTRIES];
    logic [STAT_W-1:0] r_hit_count;
    logic [STAT_W-1:0] r_mispred_count;

    logic [CTR_W-1:0]  w_ctr    [ENTRIES];
    btb_entry_t        w_entry  [ENTRIES];
    logic [IDX_W-1:0]  w_lidx, w_uidx;
    logic [29:0]       w_ltag, w_utag;
    btb_entry_t        w_lent, w_uent;
    logic              w_uhit, w_upd_hit, w_alloc;

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            w_entry[i].valid  = r_valid[i];
            w_entry[i].tag    = r_tag[i];
            w_entry[i].target = r_target[i];
            w_entry[i].ctr    = 3'(w_ctr[i]);
        end
    end

    assign w_lidx = lookup_pc[IDX_W+1:2];
    assign w_ltag = btb_tag(lookup_pc, IDX_W);
    assign w_lent = w_entry[w_lidx];
    assign w_uidx = upd_pc[IDX_W+1:2];
    assign w_utag = btb_tag(upd_pc, IDX_W);
    assign w_uent = w_entry[w_uidx];

    // Lookup reads the registered array directly, so a same-cycle update is seen next cycle.
    assign pred_hit    = w_lent.valid && (w_lent.tag == w_ltag);
    assign pred_taken  = pred_hit && (|(w_lent.ctr & WEAK3));
    assign pred_target = pred_hit ? w_lent.target : (lookup_pc + 32'd4);

    assign w_uhit    = w_uent.valid && (w_uent.tag == w_utag);
    assign w_upd_hit = upd_valid && w_uhit;
    assign w_alloc   = upd_valid && upd_taken && !w_uhit;

    assign mispredict  = upd_valid && ((upd_taken != upd_pred_taken) ||
                                       (upd_taken && (upd_pred_target != upd_target)));
    assign redirect_pc = upd_taken ? upd_target : (upd_pc + 32'd4);

    for (genvar g = 0; g < ENTRIES; g++) begin : g_ctr
        logic w_sel;
        assign w_sel = !inval_all && (w_uidx == IDX_W'(g));
        branch_predict_btb_sat_counter #(.CTR_W(CTR_W)) u_ctr (
            .clk        (clk),
            .reset      (reset),
            .i_inc      (w_sel && w_upd_hit && upd_taken),
            .i_dec      (w_sel && w_upd_hit && !upd_taken),
            .i_load     (w_sel && w_alloc),
            .i_load_val (CTR_WEAK),
            .o_count    (w_ctr[g])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
            end
        end else if (inval_all) begin
            for (int i = 0; i < ENTRIES; i++) r_valid[i] <= 1'b0;
        end else if (w_upd_hit && upd_taken) begin
            r_target[w_uidx] <= upd_target;
        end else if (w_alloc) begin
            r_valid[w_uidx]  <= 1'b1;
            r_tag[w_uidx]    <= w_utag;
            r_target[w_uidx] <= upd_target;
        end
    end

    // Statistics track resolved branches regardless of invalidation.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hit_count     <= '0;
            r_mispred_count <= '0;
        end else begin
            if (w_upd_hit && (r_hit_count != '1)) r_hit_count <= r_hit_count + STAT_W'(1);
            if (mispredict && (r_mispred_count != '1)) r_mispred_count <= r_mispred_count + STAT_W'(1);
        end
    end

    assign hit_count     = r_hit_count;
    assign mispred_count = r_mispred_count;

endmodule

// File: doc/branch_predict_btb.md
BRANCH_PREDICT_BTB -- requirements
Module: branch_predict_btb

Interface
REQ-001 Parameter ENTRIES, default 16, number of BTB entries; power of two, 4..256.
REQ-002 Parameter CTR_W, default 2, width of each saturating direction counter, 1..3.
REQ-003 Parameter STAT_W, default 16, width of each statistics counter.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 lookup_pc  in  32  fetch-stage PC being looked up.
REQ-007 pred_hit  out  1  valid entry with matching tag exists for lookup_pc.
REQ-008 pred_taken  out  1  predict taken: pred_hit and counter MSB set.
REQ-009 pred_target  out  32  stored target on hit; lookup_pc+4 otherwise.
REQ-010 upd_valid  in  1  a branch or jump resolved this cycle.
REQ-011 upd_pc  in  32  PC of the resolved instruction.
REQ-012 upd_taken  in  1  actual direction.
REQ-013 upd_target  in  32  actual taken target.
REQ-014 upd_pred_taken  in  1  prediction given at fetch for this instruction.
REQ-015 upd_pred_target  in  32  predicted target given at fetch.
REQ-016 inval_all  in  1  invalidate every entry (context or interrupt entry).
REQ-017 mispredict  out  1  resolved outcome differs from fetch prediction.
REQ-018 redirect_pc  out  32  correct next PC when mispredict is high.
REQ-019 hit_count  out  STAT_W  number of lookups that hit on updated branches.
REQ-020 mispred_count  out  STAT_W  number of mispredicts.

Function
REQ-021 Index = PC[IDX_W+1:2], tag = PC[31:IDX_W+2], IDX_W = log2(ENTRIES); direct-mapped.
REQ-022 Lookup is combinational from lookup_pc and current array contents; zero-cycle latency.
REQ-023 mispredict = upd_valid and (upd_taken != upd_pred_taken, or upd_taken and upd_pred_target != upd_target); combinational.
REQ-024 redirect_pc = upd_target if upd_taken, else upd_pc+4 (32-bit wrap).
REQ-025 Update on upd_valid, on tag hit: counter +1 if taken, -1 if not, saturating at 0 and 2^CTR_W-1; target overwritten with upd_target if taken.
REQ-026 Update on upd_valid, on miss, taken: allocate/replace entry: valid=1, tag, target=upd_target, counter=2^(CTR_W-1) (weakly taken).
REQ-027 Update on upd_valid, on miss, not taken: no allocation, array unchanged.
REQ-028 Lookup and update to same index in one cycle: lookup returns pre-update contents; new contents visible next cycle.
REQ-029 inval_all clears all valid bits next edge; counters and targets are don't-care; inval_all wins over a simultaneous update.
REQ-030 mispred_count increments on each mispredict cycle; hit_count increments on each upd_valid where the updated index held a matching valid tag; both saturate at all-ones, no wrap.
REQ-031 Statistics are not cleared by inval_all.

Reset
REQ-032 On reset: all valid bits 0, all counters 0, hit_count 0, mispred_count 0.
REQ-033 During and after reset, until an allocation occurs: pred_hit=0, pred_taken=0, pred_target=lookup_pc+4.
REQ-034 Reset asserted mid-update discards that update; reset has priority over all inputs.

Structure
REQ-035 A shared package holds BTB index/tag width functions, the weakly-taken constant and the entry record typedef (valid, tag, target, counter).
REQ-036 One sub-module sat_counter (parametrised CTR_W, inc/dec/load, saturating) is instantiated per entry or used as a function; nothing else is split out.
REQ-037 Target and tag storage is a register array, not inferred RAM, so lookup stays asynchronous.

Verification
REQ-038 After reset, lookup_pc=0x00400010 -> pred_hit=0, pred_taken=0, pred_target=0x00400014.
REQ-039 Update pc=0x00400010, taken, target=0x00400100, pred_taken=0 -> mispredict=1, redirect_pc=0x00400100; next cycle lookup same PC -> hit, taken, target 0x00400100, mispred_count=1.
REQ-040 Same PC resolved not-taken twice with CTR_W=2 -> counter 2->1->0, pred_taken=0 after the first; third not-taken holds 0; redirect_pc=0x00400014.
REQ-041 Aliasing: ENTRIES=16, allocate 0x00400010 then taken update at 0x00400050 (same index) -> 0x00400010 now misses, 0x00400050 hits.
REQ-042 Same-cycle lookup/update at same index, then inval_all asserted with a concurrent taken update -> lookup shows old data; after inval, all lookups miss; statistics retained.
REQ-043 STAT_W=4, sixteen consecutive mispredicts -> mispred_count saturates at 15.
